// File: rtl/rv64g_l1_line_xfer_pkg.sv
// Shared encodings for the L1 line-transfer sequencer: MESI states, command
// opcodes and FSM states.
package rv64g_l1_line_xfer_pkg;

    localparam int INDEX_W_DEF        = 5;
    localparam int TAG_W_DEF          = 53;
    localparam int WORDS_PER_LINE_DEF = 8;
    localparam int WAY_W              = 3;

    typedef enum logic [1:0] {
        MESI_N = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    localparam logic XFER_OP_FILL  = 1'b0;
    localparam logic XFER_OP_EVICT = 1'b1;

    typedef enum logic [2:0] {
        XFER_IDLE,
        XFER_FILL,
        XFER_FILL_TAG,
        XFER_EVICT,
        XFER_EVICT_INV
    } xfer_state_e;

endpackage

// File: rtl/rv64g_l1_line_xfer_if.sv
// Command, refill, writeback and SRAM-bank signals of the line-transfer
// sequencer; slave is the sequencer side, master the controller/bank side.
interface rv64g_l1_line_xfer_if
    import rv64g_l1_line_xfer_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
);

    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic               cmd_op_i;
    logic [INDEX_W-1:0] cmd_index_i;
    logic [WAY_W-1:0]   cmd_way_i;
    logic [TAG_W-1:0]   cmd_tag_i;
    logic [1:0]         cmd_state_i;

    logic               fill_valid_i;
    logic               fill_ready_o;
    logic [63:0]        fill_data_i;

    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [63:0]        wb_data_o;
    logic               wb_last_o;

    logic               done_o;
    logic               busy_o;

    logic               bank_req_o;
    logic               bank_we_o;
    logic               bank_tag_we_o;
    logic [INDEX_W-1:0] bank_index_o;
    logic [2:0]         bank_word_o;
    logic [WAY_W-1:0]   bank_way_o;
    logic [7:0]         bank_be_o;
    logic [63:0]        bank_wdata_o;
    logic [TAG_W-1:0]   bank_tag_o;
    logic [1:0]         bank_state_o;
    logic [63:0]        bank_rdata_i;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_index_i, cmd_way_i, cmd_tag_i, cmd_state_i,
        input  fill_valid_i, fill_data_i, wb_ready_i, bank_rdata_i,
        output cmd_ready_o, fill_ready_o, wb_valid_o, wb_data_o, wb_last_o,
        output done_o, busy_o, bank_req_o, bank_we_o, bank_tag_we_o, bank_index_o,
        output bank_word_o, bank_way_o, bank_be_o, bank_wdata_o, bank_tag_o, bank_state_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_index_i, cmd_way_i, cmd_tag_i, cmd_state_i,
        output fill_valid_i, fill_data_i, wb_ready_i, bank_rdata_i,
        input  cmd_ready_o, fill_ready_o, wb_valid_o, wb_data_o, wb_last_o,
        input  done_o, busy_o, bank_req_o, bank_we_o, bank_tag_we_o, bank_index_o,
        input  bank_word_o, bank_way_o, bank_be_o, bank_wdata_o, bank_tag_o, bank_state_o
    );

endinterface

// File: rtl/rv64g_l1_line_xfer_ctr.sv
// Word counter for one line transfer, with a flag on the final word.
module rv64g_l1_line_xfer_ctr #(
    parameter  int WORDS_PER_LINE = 8,
    localparam int CTR_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] cnt_o,
    output logic             last_o
);

    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(WORDS_PER_LINE - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

    assign last_o = (cnt_o == CTR_LAST);

endmodule

// File: rtl/rv64g_l1_line_xfer.sv
// Line-transfer sequencer on the single R/W port of one L1 SRAM bank:
// fills stream refill words in then write tag/state, evicts stream words out then invalidate.
module rv64g_l1_line_xfer
    import rv64g_l1_line_xfer_pkg::*;
#(
    parameter int INDEX_W        = INDEX_W_DEF,
    parameter int TAG_W          = TAG_W_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input logic                  clk_i,
    input logic                  rst_i,
    rv64g_l1_line_xfer_if.slave  bus
);

    localparam int CTR_W = $clog2(WORDS_PER_LINE);

    xfer_state_e        state_q, state_d;
    logic [CTR_W-1:0]   ctr;
    logic               ctr_last;
    logic               ctr_clr;
    logic               ctr_inc;
    logic               accept;
    logic [INDEX_W-1:0] index_q;
    logic [WAY_W-1:0]   way_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         mesi_q;

    rv64g_l1_line_xfer_ctr #(
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_ctr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (ctr_clr),
        .inc_i  (ctr_inc),
        .cnt_o  (ctr),
        .last_o (ctr_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= XFER_IDLE;
            index_q <= '0;
            way_q   <= '0;
            tag_q   <= '0;
            mesi_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                index_q <= bus.cmd_index_i;
                way_q   <= bus.cmd_way_i;
                tag_q   <= bus.cmd_tag_i;
                mesi_q  <= bus.cmd_state_i;
            end
        end
    end

    assign bus.bank_index_o = index_q;
    assign bus.bank_way_o   = way_q;

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        ctr_clr           = 1'b0;
        ctr_inc           = 1'b0;
        bus.cmd_ready_o   = 1'b0;
        bus.fill_ready_o  = 1'b0;
        bus.wb_valid_o    = 1'b0;
        bus.wb_data_o     = '0;
        bus.wb_last_o     = 1'b0;
        bus.done_o        = 1'b0;
        bus.busy_o        = 1'b1;
        bus.bank_req_o    = 1'b0;
        bus.bank_we_o     = 1'b0;
        bus.bank_tag_we_o = 1'b0;
        bus.bank_word_o   = '0;
        bus.bank_be_o     = '0;
        bus.bank_wdata_o  = '0;
        bus.bank_tag_o    = '0;
        bus.bank_state_o  = MESI_N;

        unique case (state_q)
            XFER_IDLE: begin
                bus.cmd_ready_o = 1'b1;
                bus.busy_o      = 1'b0;
                if (bus.cmd_valid_i) begin
                    accept  = 1'b1;
                    ctr_clr = 1'b1;
                    state_d = (bus.cmd_op_i == XFER_OP_EVICT) ? XFER_EVICT : XFER_FILL;
                end
            end
            XFER_FILL: begin
                bus.fill_ready_o = 1'b1;
                bus.bank_req_o   = bus.fill_valid_i;
                bus.bank_we_o    = bus.fill_valid_i;
                bus.bank_be_o    = '1;
                bus.bank_wdata_o = bus.fill_data_i;
                bus.bank_word_o  = ctr;
                // Exit decoded on the last word; counter is cleared rather than wrapped.
                if (bus.fill_valid_i) begin
                    if (ctr_last) begin
                        ctr_clr = 1'b1;
                        state_d = XFER_FILL_TAG;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
            end
            XFER_FILL_TAG: begin
                bus.bank_req_o    = 1'b1;
                bus.bank_tag_we_o = 1'b1;
                bus.bank_tag_o    = tag_q;
                bus.bank_state_o  = mesi_q;
                bus.done_o        = 1'b1;
                state_d           = XFER_IDLE;
            end
            XFER_EVICT: begin
                // Read data is combinational from the held address, so it stays stable under backpressure.
                bus.bank_word_o = ctr;
                bus.wb_valid_o  = 1'b1;
                bus.wb_data_o   = bus.bank_rdata_i;
                bus.wb_last_o   = ctr_last;
                if (bus.wb_ready_i) begin
                    if (ctr_last) begin
                        ctr_clr = 1'b1;
                        state_d = XFER_EVICT_INV;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
            end
            XFER_EVICT_INV: begin
                bus.bank_req_o    = 1'b1;
                bus.bank_tag_we_o = 1'b1;
                bus.bank_tag_o    = tag_q;
                bus.bank_state_o  = MESI_N;
                bus.done_o        = 1'b1;
                state_d           = XFER_IDLE;
            end
            default: state_d = XFER_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv64g_l1_line_xfer.sv
// Scoreboard bench for rv64g_l1_line_xfer: a line-level cache model predicts bank
// writes, tag writes, writeback words and done pulses; a monitor checks them.
module tb_rv64g_l1_line_xfer;
    import rv64g_l1_line_xfer_pkg::*;

    localparam int INDEX_W = 5;
    localparam int TAG_W   = 53;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv64g_l1_line_xfer_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus ();

    rv64g_l1_line_xfer #(
        .INDEX_W        (INDEX_W),
        .TAG_W          (TAG_W),
        .WORDS_PER_LINE (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  idx;
        logic [2:0]  way;
        logic [2:0]  word;
        logic [7:0]  be;
        logic [63:0] data;
    } wr_t;
    typedef struct packed {
        logic [4:0]       idx;
        logic [2:0]       way;
        logic [TAG_W-1:0] tag;
        logic [1:0]       st;
    } tw_t;
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } wb_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cyc     = 0;
    int exp_done    = 0;
    int exp_accepts = 0;
    int act_accepts = 0;

    wr_t exp_wr[$];
    tw_t exp_tw[$];
    wb_t exp_wb[$];

    // Physical bank contents, written only by the DUT's bank port.
    logic [63:0]      mem    [32][8][8];
    logic [TAG_W-1:0] tag_arr[32][8];
    logic [1:0]       st_arr [32][8];
    // Reference cache contents, updated when a command is issued.
    logic [63:0]      ref_mem[32][8][8];
    logic [TAG_W-1:0] ref_tag[32][8];
    logic [1:0]       ref_st [32][8];
    logic [63:0]      line_buf[8];

    assign bus.bank_rdata_i = mem[bus.bank_index_o][bus.bank_way_o][bus.bank_word_o];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.bank_req_o && bus.bank_we_o)
            for (int b = 0; b < 8; b++)
                if (bus.bank_be_o[b])
                    mem[bus.bank_index_o][bus.bank_way_o][bus.bank_word_o][b*8 +: 8] <= bus.bank_wdata_o[b*8 +: 8];
        if (bus.bank_req_o && bus.bank_tag_we_o) begin
            tag_arr[bus.bank_index_o][bus.bank_way_o] <= bus.bank_tag_o;
            st_arr[bus.bank_index_o][bus.bank_way_o]  <= bus.bank_state_o;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compares every observable transfer against the scoreboard queues.
    logic        stall_prev = 1'b0;
    logic [63:0] prev_wb    = '0;
    logic        prev_done  = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (bus.bank_req_o && bus.bank_we_o) begin
                wr_t a;
                a = {bus.bank_index_o, bus.bank_way_o, bus.bank_word_o, bus.bank_be_o, bus.bank_wdata_o};
                if (exp_wr.size() == 0) fail_now($sformatf("bank_write unexpected %0h", a));
                else chk("bank_write", a, exp_wr.pop_front());
            end
            if (bus.bank_req_o && bus.bank_tag_we_o) begin
                tw_t t;
                t = {bus.bank_index_o, bus.bank_way_o, bus.bank_tag_o, bus.bank_state_o};
                chk("tag_and_data_write_overlap", bus.bank_we_o, 1'b0);
                if (exp_tw.size() == 0) fail_now($sformatf("tag_write unexpected %0h", t));
                else chk("tag_write", t, exp_tw.pop_front());
            end
            if (bus.wb_valid_o && bus.wb_ready_i) begin
                wb_t w;
                w = {bus.wb_data_o, bus.wb_last_o};
                if (exp_wb.size() == 0) fail_now($sformatf("wb_word unexpected %0h", w));
                else chk("wb_word", w, exp_wb.pop_front());
            end
            if (stall_prev && bus.wb_valid_o) chk("wb_data_stall_stable", bus.wb_data_o, prev_wb);
            if (bus.done_o) begin
                if (exp_done == 0) fail_now("done_o unexpected");
                else exp_done--;
            end
            if (prev_done) chk("cmd_ready_after_done", bus.cmd_ready_o, 1'b1);
            chk("cmd_ready_vs_busy", bus.cmd_ready_o, !bus.busy_o);
            if (bus.cmd_valid_i && bus.cmd_ready_o) act_accepts++;
            stall_prev = bus.wb_valid_o && !bus.wb_ready_i;
            prev_wb    = bus.wb_data_o;
            prev_done  = bus.done_o;
        end
    end

    task automatic check_reset_outputs(input string name);
        logic [255:0] rest;
        rest = {bus.fill_ready_o, bus.wb_valid_o, bus.wb_data_o, bus.wb_last_o, bus.done_o,
                bus.busy_o, bus.bank_req_o, bus.bank_we_o, bus.bank_tag_we_o, bus.bank_index_o,
                bus.bank_word_o, bus.bank_way_o, bus.bank_be_o, bus.bank_wdata_o, bus.bank_tag_o,
                bus.bank_state_o};
        chk({name, "_cmd_ready"}, bus.cmd_ready_o, 1'b1);
        chk({name, "_outputs_zero"}, rest, '0);
    endtask

    task automatic issue_cmd(input logic op, input logic [4:0] idx, input logic [2:0] way,
                             input logic [TAG_W-1:0] tag, input logic [1:0] st);
        int  g;
        bit  got;
        g   = 0;
        got = 0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_index_i = idx;
        bus.cmd_way_i   = way;
        bus.cmd_tag_i   = tag;
        bus.cmd_state_i = st;
        exp_accepts++;
        while (!got && g < 200) begin
            @(negedge clk);
            g++;
            if (bus.cmd_ready_o) begin
                got     = 1;
                acc_cyc = cyc;
            end
        end
        if (!got) fail_now("cmd_accept timeout");
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic do_fill(input logic [4:0] idx, input logic [2:0] way, input logic [TAG_W-1:0] tag,
                           input logic [1:0] st, input int nwords, input int gap_mask, input int gap_len);
        for (int i = 0; i < nwords; i++) begin
            exp_wr.push_back({idx, way, 3'(i), 8'hFF, line_buf[i]});
            ref_mem[idx][way][i] = line_buf[i];
        end
        if (nwords == 8) begin
            exp_tw.push_back({idx, way, tag, st});
            exp_done++;
            ref_tag[idx][way] = tag;
            ref_st[idx][way]  = st;
        end
        issue_cmd(XFER_OP_FILL, idx, way, tag, st);
        for (int i = 0; i < nwords; i++) begin
            int g;
            if (gap_mask[i]) begin
                bus.fill_valid_i = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; end
            end
            bus.fill_valid_i = 1'b1;
            bus.fill_data_i  = line_buf[i];
            g = 0;
            @(negedge clk);
            while (!bus.fill_ready_o && g < 50) begin @(negedge clk); g++; end
            if (g == 50) fail_now("fill_ready timeout");
            @(posedge clk);
            #1;
        end
        bus.fill_valid_i = 1'b0;
        bus.fill_data_i  = '0;
    endtask

    task automatic do_evict(input logic [4:0] idx, input logic [2:0] way,
                            input int stall_word, input int stall_len, input bit rnd);
        int acc, stalled, g;
        for (int i = 0; i < 8; i++) exp_wb.push_back({ref_mem[idx][way][i], i == 7});
        exp_tw.push_back({idx, way, ref_tag[idx][way], 2'(MESI_N)});
        exp_done++;
        ref_st[idx][way] = MESI_N;
        issue_cmd(XFER_OP_EVICT, idx, way, ref_tag[idx][way], 2'($urandom));
        acc = 0; stalled = 0; g = 0;
        while (acc < 8 && g < 300) begin
            g++;
            if (bus.wb_valid_o) begin
                bit rdy;
                if (acc == stall_word && stalled < stall_len) begin
                    rdy = 0;
                    stalled++;
                end else if (rnd) begin
                    rdy = ($urandom % 3) != 0;
                end else begin
                    rdy = 1;
                end
                bus.wb_ready_i = rdy;
                if (rdy) acc++;
            end else begin
                bus.wb_ready_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 8) fail_now("wb_stream timeout");
        bus.wb_ready_i = 1'b0;
    endtask

    // Accept edge to the edge that consumes done_o.
    task automatic check_done_latency(input string name);
        int g;
        g = 0;
        @(negedge clk);
        while (bus.done_o !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        if (g == 50) fail_now({name, " timeout"});
        else chk(name, cyc - acc_cyc, 9);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  r_idx;
        logic [2:0]  r_way;
        logic [63:0] r64;

        bus.cmd_valid_i  = 1'b0;
        bus.cmd_op_i     = 1'b0;
        bus.cmd_index_i  = '0;
        bus.cmd_way_i    = '0;
        bus.cmd_tag_i    = '0;
        bus.cmd_state_i  = '0;
        bus.fill_valid_i = 1'b0;
        bus.fill_data_i  = '0;
        bus.wb_ready_i   = 1'b0;
        for (int s = 0; s < 32; s++)
            for (int w = 0; w < 8; w++) begin
                r64 = {$urandom, $urandom};
                tag_arr[s][w] = r64[TAG_W-1:0];
                ref_tag[s][w] = r64[TAG_W-1:0];
                st_arr[s][w]  = MESI_N;
                ref_st[s][w]  = MESI_N;
                for (int k = 0; k < 8; k++) begin
                    r64 = {$urandom, $urandom};
                    mem[s][w][k]     = r64;
                    ref_mem[s][w][k] = r64;
                end
            end

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Continuous fill of set 5 way 3.
        for (int i = 0; i < 8; i++) line_buf[i] = 64'h1000 + 64'(i);
        do_fill(5'd5, 3'd3, 53'h1ABC, MESI_E, 8, 0, 0);
        check_done_latency("fill_done_latency");
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) chk($sformatf("readback_w%0d", i), mem[5][3][i], 64'h1000 + 64'(i));
        chk("readback_tag", tag_arr[5][3], 53'h1ABC);
        chk("readback_state", st_arr[5][3], MESI_E);

        // Same fill with valid gaps after words 2 and 5.
        do_fill(5'd5, 3'd3, 53'h1ABC, MESI_E, 8, (1 << 3) | (1 << 6), 2);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) chk($sformatf("gap_readback_w%0d", i), mem[5][3][i], 64'h1000 + 64'(i));

        // Evict with a three-cycle stall on word 4.
        do_evict(5'd5, 3'd3, 4, 3, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("evict_state_invalid", st_arr[5][3], MESI_N);

        // Second command held valid across a whole fill.
        for (int i = 0; i < 8; i++) line_buf[i] = {$urandom, $urandom};
        fork
            do_fill(5'd7, 3'd1, 53'h0F00D, MESI_M, 8, 0, 0);
            begin
                repeat (3) @(posedge clk);
                #2;
                do_evict(5'd7, 3'd1, 0, 0, 0);
            end
        join
        repeat (2) begin @(posedge clk); #1; end

        // Reset after four fill words.
        for (int i = 0; i < 8; i++) line_buf[i] = {$urandom, $urandom};
        do_fill(5'd9, 3'd2, 53'h777, MESI_M, 4, 0, 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midfill_reset");
        @(negedge clk);
        chk("midfill_state_unchanged", st_arr[9][2], MESI_N);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back evict way 0 then fill way 7 of set 12.
        do_evict(5'd12, 3'd0, 0, 0, 0);
        check_done_latency("evict_done_latency");
        for (int i = 0; i < 8; i++) line_buf[i] = {$urandom, $urandom};
        do_fill(5'd12, 3'd7, 53'h12345, MESI_S, 8, 0, 0);
        repeat (2) begin @(posedge clk); #1; end

        for (int n = 0; n < 30; n++) begin
            r_idx = 5'($urandom);
            r_way = 3'($urandom);
            if (ref_st[r_idx][r_way] == MESI_N || ($urandom % 2) == 0) begin
                for (int i = 0; i < 8; i++) line_buf[i] = {$urandom, $urandom};
                r64 = {$urandom, $urandom};
                do_fill(r_idx, r_way, r64[TAG_W-1:0], 2'($urandom_range(1, 3)), 8,
                        int'($urandom % 256), int'($urandom_range(1, 3)));
            end else begin
                do_evict(r_idx, r_way, int'($urandom % 8), int'($urandom % 4), 1);
            end
            repeat ($urandom % 2) begin @(posedge clk); #1; end
        end

        repeat (4) begin @(posedge clk); #1; end
        chk("pending_bank_writes", exp_wr.size(), 0);
        chk("pending_tag_writes", exp_tw.size(), 0);
        chk("pending_wb_words", exp_wb.size(), 0);
        chk("pending_done", exp_done, 0);
        chk("accept_count", act_accepts, exp_accepts);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
